// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin burst arbiter sharing the async FIFO read port
//
// Purpose:
//   Shares the rclk-domain read port of the async FIFO between NUM_REQ
//   consumers. A round-robin grant with a burst cap drives fifo_r_en, and each
//   returned word is tagged with the index of the consumer that owns it.
//
// Ports:
//   rclk        in   read-domain clock
//   rrst_n      in   asynchronous active-low reset
//   req         in   level request per consumer, held while wanting data
//   fifo_empty  in   registered empty flag from the read-pointer handler
//   fifo_rdata  in   FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en   out  FIFO read enable (combinational)
//   gnt         out  one-hot grant (registered)
//   rd_valid    out  rd_data/rd_id valid this cycle
//   rd_data     out  pass-through of fifo_rdata
//   rd_id       out  consumer index owning rd_data
//
// Build option:
//   EMPTY_RELEASE_EN - when defined, an owner that sees fifo_empty gives up
//   its grant immediately instead of stalling on it.

module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ID_W-1:0]       rd_id
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_owner;
  logic [ID_W-1:0]    r_last;
  logic [CNT_W-1:0]   r_count;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_rd_valid;
  logic [ID_W-1:0]    r_rd_id;

  logic               w_found;
  logic [ID_W-1:0]    w_pick;
  logic [ID_W-1:0]    w_idx;
  logic               w_owner_req;
  logic               w_rd_en;
  logic               w_last_beat;

  // Search starts one past the previous winner so every waiting requester
  // is reached within NUM_REQ-1 grants.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = r_last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = ID_W'((int'(r_last) + i) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // A beat needs the owner still requesting and data available; an owner
  // dropping req therefore never receives a word in its drop cycle.
  assign w_owner_req = req[r_owner];
  assign w_rd_en     = (r_state == BURST) && w_owner_req && !fifo_empty;
  assign w_last_beat = w_rd_en && (r_count == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= ID_W'(NUM_REQ - 1);
      r_count    <= '0;
      r_gnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= '0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_id <= r_owner;
      end
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_found) begin
            r_owner <= w_pick;
            r_gnt   <= NUM_REQ'(1) << w_pick;
            r_state <= BURST;
          end else begin
            r_gnt <= '0;
          end
        end
        BURST: begin
          if (!w_owner_req || w_last_beat) begin
            r_gnt   <= '0;
            r_last  <= r_owner;
            r_state <= IDLE;
          end else if (w_rd_en) begin
            r_count <= r_count + CNT_W'(1);
`ifdef EMPTY_RELEASE_EN
          end else if (fifo_empty) begin
            r_gnt   <= '0;
            r_last  <= r_owner;
            r_state <= IDLE;
`endif
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fifo_r_en = w_rd_en;
  assign gnt       = r_gnt;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = fifo_rdata;
  assign rd_id     = r_rd_id;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb/tb_fifo_rd_arbiter.sv - directed and random bench for fifo_rd_arbiter
module tb_fifo_rd_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int BURST_LEN  = 4;
  localparam int ID_W       = 2;

  logic                  rclk = 1'b0;
  logic                  rrst_n = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic                  fifo_empty = 1'b1;
  logic [DATA_WIDTH-1:0] fifo_rdata = '0;
  logic                  fifo_r_en;
  logic [NUM_REQ-1:0]    gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ID_W-1:0]       rd_id;

  int checks = 0;
  int errors = 0;

  logic [DATA_WIDTH-1:0]      mem[$];
  logic [ID_W+DATA_WIDTH-1:0] exp_q[$];
  logic [NUM_REQ-1:0]         gnt_log[$];
  logic                       force_empty = 1'b0;
  logic                       sb_on = 1'b1;

  fifo_rd_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .rclk(rclk),
    .rrst_n(rrst_n),
    .req(req),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_r_en(fifo_r_en),
    .gnt(gnt),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_id(rd_id)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // FIFO model: data one cycle after r_en; empty flag registered shortly after the edge.
  always @(posedge rclk) begin
    if (fifo_r_en) fifo_rdata <= mem.pop_front();
    #2;
    fifo_empty = (mem.size() == 0) || force_empty;
  end

  // Monitor: scoreboard pops and protocol invariants, sampled at the falling edge.
  logic [NUM_REQ-1:0] prev_gnt = '0;
  logic [NUM_REQ-1:0] prev_req = '0;
  logic [NUM_REQ-1:0] beat_gnt = '0;
  int beats = 0;
  int wait_cnt[NUM_REQ];

  always @(negedge rclk) begin
    if (!rrst_n) begin
      prev_gnt = '0;
      beat_gnt = '0;
      beats = 0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    end else begin
      if (sb_on && rd_valid) begin
        if (exp_q.size() == 0) chk("rd_extra", 32'(rd_valid), 32'd0);
        else chk("rd_word", 32'({rd_id, rd_data}), 32'(exp_q.pop_front()));
      end
      chk("no_underflow", 32'(fifo_r_en & fifo_empty), 32'd0);
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("ren_owner", 32'(!fifo_r_en || (|(gnt & req))), 32'd1);
      if (gnt == '0 || gnt != beat_gnt) beats = 0;
      beat_gnt = gnt;
      if (fifo_r_en) begin
        beats++;
        chk("burst_cap", 32'(beats <= BURST_LEN), 32'd1);
      end
      if (gnt != '0 && prev_gnt == '0) begin
        gnt_log.push_back(gnt);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (gnt[i]) wait_cnt[i] = 0;
          else if (prev_req[i]) begin
            wait_cnt[i]++;
            chk("fairness", 32'(wait_cnt[i] <= NUM_REQ - 1), 32'd1);
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) if (!req[i]) wait_cnt[i] = 0;
      prev_gnt = gnt;
    end
    prev_req = req;
  end

  task automatic do_reset();
    rrst_n = 1'b0;
    req = '0;
    force_empty = 1'b0;
    mem.delete();
    exp_q.delete();
    gnt_log.delete();
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1;
  endtask

  task automatic load(input int base, input int n, input int id, input bit expect_it);
    for (int k = 0; k < n; k++) begin
      mem.push_back(DATA_WIDTH'(base + k));
      if (expect_it) exp_q.push_back({ID_W'(id), DATA_WIDTH'(base + k)});
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge rclk);
      n++;
    end
    @(negedge rclk);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] order[5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    do_reset();
    @(negedge rclk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_id", 32'(rd_id), 32'd0);
    chk("rst_r_en", 32'(fifo_r_en), 32'd0);

    // Single requester, 10 words: 4-beat bursts, one IDLE cycle, re-granted
    @(posedge rclk); #1;
    load(8'h10, 10, 0, 1'b1);
    req = 4'b0001;
    @(negedge rclk);
    chk("t1_idle_gnt", 32'(gnt), 32'd0);
    @(negedge rclk);
    chk("t1_gnt", 32'(gnt), 32'b0001);
    repeat (4) @(negedge rclk);
    chk("t1_exit_gnt", 32'(gnt), 32'd0);
    chk("t1_last_valid", 32'(rd_valid), 32'd1);
    @(negedge rclk);
    chk("t1_regrant", 32'(gnt), 32'b0001);
    drain("t1_drain");
    @(posedge rclk); #1 req = '0;
    repeat (3) @(posedge rclk);

    // All requesting, FIFO never empty: order 0,1,2,3,0 with 4 beats each
    do_reset();
    load(8'h20, 20, 0, 1'b0);
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < 4; b++) exp_q.push_back({ID_W'(g % 4), DATA_WIDTH'(8'h20 + g * 4 + b)});
    req = 4'b1111;
    drain("t2_drain");
    chk("t2_nlog", 32'(gnt_log.size() >= 5), 32'd1);
    for (int g = 0; g < 5; g++)
      if (g < gnt_log.size()) chk($sformatf("t2_order%0d", g), 32'(gnt_log[g]), 32'(order[g]));
    @(posedge rclk); #1 req = '0;
    repeat (3) @(posedge rclk);

    // Owner 1 drops after 2 beats, grant moves to 2
    do_reset();
    load(8'h40, 2, 1, 1'b1);
    load(8'h42, 4, 2, 1'b1);
    req = 4'b0110;
    repeat (3) @(posedge rclk);
    #1 req = 4'b0100;
    @(negedge rclk);
    chk("t3_drop_ren", 32'(fifo_r_en), 32'd0);
    @(negedge rclk);
    chk("t3_exit_gnt", 32'(gnt), 32'd0);
    @(negedge rclk);
    chk("t3_next_gnt", 32'(gnt), 32'b0100);
    drain("t3_drain");
    @(posedge rclk); #1 req = '0;
    repeat (3) @(posedge rclk);

    // FIFO empties after one beat, refilled later
    do_reset();
`ifdef EMPTY_RELEASE_EN
    sb_on = 1'b0;
    load(8'h60, 1, 0, 1'b0);
`else
    load(8'h60, 1, 0, 1'b1);
`endif
    req = 4'b0011;
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    chk("t4_stall_ren", 32'(fifo_r_en), 32'd0);
`ifdef EMPTY_RELEASE_EN
    chk("t4_release_gnt", 32'(gnt), 32'd0);
`else
    chk("t4_hold_gnt", 32'(gnt), 32'b0001);
`endif
    repeat (4) @(posedge rclk);
    #1;
`ifdef EMPTY_RELEASE_EN
    load(8'h61, 3, 0, 1'b0);
    repeat (20) @(posedge rclk);
`else
    load(8'h61, 3, 0, 1'b1);
    drain("t4_drain");
    repeat (3) @(posedge rclk);
`endif
    chk("t4_nlog", 32'(gnt_log.size() >= 2), 32'd1);
    if (gnt_log.size() >= 2) chk("t4_next_owner", 32'(gnt_log[1]), 32'b0010);
    @(posedge rclk); #1 req = '0;
    repeat (3) @(posedge rclk);
    sb_on = 1'b1;

    // Reset asserted mid-burst (count=2): in-flight word dropped
    do_reset();
    load(8'h80, 10, 0, 1'b0);
    exp_q.push_back({ID_W'(0), 8'h80});
    req = 4'b0001;
    repeat (3) @(posedge rclk);
    #1 rrst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    chk("t5_rst_valid", 32'(rd_valid), 32'd0);
    chk("t5_rst_ren", 32'(fifo_r_en), 32'd0);
    chk("t5_exp", 32'(exp_q.size()), 32'd0);
    req = '0;
    mem.delete();
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1;
    req = 4'b1111;
    @(negedge rclk);
    @(negedge rclk);
    chk("t5_regrant", 32'(gnt), 32'b0001);
    @(posedge rclk); #1 req = '0;
    repeat (3) @(posedge rclk);

    // Random requests and empty flag: invariants checked by the monitor
    do_reset();
    sb_on = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge rclk); #1;
      if ($urandom_range(0, 7) == 0) req = NUM_REQ'($urandom);
      force_empty = ($urandom_range(0, 3) == 0);
      while (mem.size() < 8) mem.push_back(DATA_WIDTH'($urandom));
    end
    req = '0;
    force_empty = 1'b0;
    repeat (5) @(posedge rclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
